// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM arbiter: FSM states, port ids, burst geometry.
package sdram_pkg;

  typedef enum logic [2:0] {
    ST_DRAIN = 3'd0,
    ST_IDLE  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_ACK   = 3'd4,
    ST_COOL  = 3'd5
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_VID = 1'b1;

  localparam int BURST_LEN  = 32;
  localparam int BURST_BITS = $clog2(BURST_LEN);

  // Word-offset bits inside one video burst; cleared to align the burst base.
  localparam logic [BURST_BITS-1:0] BURST_OFS_MASK = BURST_BITS'(BURST_LEN - 1);

endpackage

// File: rtl/sdram_arb_timer.sv
// Shared up-counter with clear and terminal-count flag; one cycle per increment.
// No handshake: the owner decides each cycle whether to clear or count.
module arb_timer #(
  parameter int TERM = 64,
  parameter int W    = $clog2(TERM) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == W'(TERM - 1));

endmodule

// File: rtl/sdram_arb.sv
// Round-robin CPU/video arbiter in front of sdram_ctl; strobe one cycle after grant, ack one cycle after ctl_data_ready.
// Requesters hold req until ack; a watchdog forces ack after TIMEOUT_CYCLES so nobody hangs.
module sdram_arb
  import sdram_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ADDR_W         = 25,
  parameter int DATA_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic              ctl_refresh_data,
  output logic              ctl_write_en,
  output logic              ctl_burst_en,
  output logic [ADDR_W-1:0] ctl_addr,
  output logic [DATA_W-1:0] ctl_data_in,
  input  logic [DATA_W-1:0] ctl_data_out,
  input  logic              ctl_data_ready,
  input  logic              ctl_mem_ready,
  output logic              busy,
  output logic              err
);

  localparam logic [ADDR_W-1:0] VID_ALIGN_MASK = ~ADDR_W'(BURST_OFS_MASK);

  state_t            r_state;
  logic              r_rr_last;
  logic              r_owner;
  logic              r_cpu_ack;
  logic              r_vid_ack;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic              r_refresh;
  logic              r_write_en;
  logic              r_burst_en;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data_in;
  logic              r_busy;
  logic              r_err;

  logic w_tmr_clr;
  logic w_tmr_en;
  logic w_tmr_tc;
  logic w_grant_cpu;

  // One counter serves both the post-reset drain and the completion watchdog.
  always_comb begin
    w_tmr_clr = 1'b1;
    w_tmr_en  = 1'b0;
    case (r_state)
      ST_DRAIN: begin
        w_tmr_clr = !ctl_mem_ready;
        w_tmr_en  = ctl_mem_ready && !w_tmr_tc;
      end
      ST_WAIT: begin
        w_tmr_clr = 1'b0;
        w_tmr_en  = 1'b1;
      end
      default: begin
        w_tmr_clr = 1'b1;
        w_tmr_en  = 1'b0;
      end
    endcase
  end

  arb_timer #(
    .TERM (TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_tmr_clr),
    .i_en  (w_tmr_en),
    .o_tc  (w_tmr_tc)
  );

  assign w_grant_cpu = cpu_req && (!vid_req || (r_rr_last == PORT_VID));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_DRAIN;
      r_rr_last   <= PORT_VID;
      r_owner     <= PORT_CPU;
      r_cpu_ack   <= 1'b0;
      r_vid_ack   <= 1'b0;
      r_cpu_rdata <= '0;
      r_refresh   <= 1'b0;
      r_write_en  <= 1'b0;
      r_burst_en  <= 1'b0;
      r_addr      <= '0;
      r_data_in   <= '0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_cpu_ack <= 1'b0;
      r_vid_ack <= 1'b0;
      r_refresh <= 1'b0;
      case (r_state)
        ST_DRAIN: begin
          // Stale ctl_data_ready from a pre-reset transaction is swallowed here.
          if (ctl_mem_ready && w_tmr_tc) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_busy  <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (w_grant_cpu) begin
            r_addr     <= cpu_addr;
            r_write_en <= cpu_we;
            r_burst_en <= 1'b0;
            r_data_in  <= cpu_wdata;
            r_owner    <= PORT_CPU;
            r_rr_last  <= PORT_CPU;
            r_refresh  <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= ST_ISSUE;
          end else if (vid_req) begin
            r_addr     <= vid_addr & VID_ALIGN_MASK;
            r_write_en <= 1'b0;
            r_burst_en <= 1'b1;
            r_data_in  <= '0;
            r_owner    <= PORT_VID;
            r_rr_last  <= PORT_VID;
            r_refresh  <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (ctl_data_ready || w_tmr_tc) begin
            if (ctl_data_ready && (r_owner == PORT_CPU) && !r_write_en) begin
              r_cpu_rdata <= ctl_data_out;
            end
            if (!ctl_data_ready) begin
              r_err <= 1'b1;
            end
            r_cpu_ack <= (r_owner == PORT_CPU);
            r_vid_ack <= (r_owner == PORT_VID);
            r_state   <= ST_ACK;
          end
        end
        ST_ACK: begin
          r_state <= ST_COOL;
        end
        ST_COOL: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_DRAIN;
        end
      endcase
    end
  end

  assign cpu_ack          = r_cpu_ack;
  assign vid_ack          = r_vid_ack;
  assign cpu_rdata        = r_cpu_rdata;
  assign ctl_refresh_data = r_refresh;
  assign ctl_write_en     = r_write_en;
  assign ctl_burst_en     = r_burst_en;
  assign ctl_addr         = r_addr;
  assign ctl_data_in      = r_data_in;
  assign busy             = r_busy;
  assign err              = r_err;

endmodule

// File: tb/tb_sdram_arb.sv
// Scoreboard bench for sdram_arb with a small behavioural controller model.
module tb_sdram_arb;

  localparam int TO  = 64;
  localparam int AW  = 25;
  localparam int DW  = 16;
  localparam int LAT = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, cpu_ack;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          vid_req, vid_ack;
  logic [AW-1:0] vid_addr;
  logic          ctl_refresh_data, ctl_write_en, ctl_burst_en;
  logic [AW-1:0] ctl_addr;
  logic [DW-1:0] ctl_data_in, ctl_data_out;
  logic          ctl_data_ready, ctl_mem_ready;
  logic          busy, err;

  always #5 clk = ~clk;

  sdram_arb #(.TIMEOUT_CYCLES(TO), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .ctl_refresh_data(ctl_refresh_data), .ctl_write_en(ctl_write_en),
    .ctl_burst_en(ctl_burst_en), .ctl_addr(ctl_addr), .ctl_data_in(ctl_data_in),
    .ctl_data_out(ctl_data_out), .ctl_data_ready(ctl_data_ready),
    .ctl_mem_ready(ctl_mem_ready), .busy(busy), .err(err)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic          burst;
    logic [DW-1:0] din;
    logic          chk_din;
  } cmd_t;

  typedef struct {
    logic          port;
    logic          is_rd;
    logic [DW-1:0] rdata;
    int            lat;
  } ack_t;

  cmd_t cmd_q[$];
  ack_t ack_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic          mute = 1'b0;
  int            dr_cnt = 0;
  logic [DW-1:0] dr_data;
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic          prev_str = 1'b0;
  logic          prev_ack = 1'b0;
  logic          in_txn = 1'b0;
  logic [AW-1:0] h_addr;
  logic          h_we, h_burst;
  int            str_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input logic [AW-1:0] a, input logic we, input logic b,
                          input logic [DW-1:0] d, input logic cd);
    cmd_t c;
    c.addr = a; c.we = we; c.burst = b; c.din = d; c.chk_din = cd;
    cmd_q.push_back(c);
  endtask

  task automatic push_ack(input logic p, input logic rd, input logic [DW-1:0] rdat, input int lat);
    ack_t k;
    k.port = p; k.is_rd = rd; k.rdata = rdat; k.lat = lat;
    ack_q.push_back(k);
  endtask

  function automatic logic hit(input int which);
    case (which)
      0:       return cpu_ack;
      1:       return vid_ack;
      2:       return ctl_refresh_data;
      default: return !busy;
    endcase
  endfunction

  task automatic wait_evt(input int which, input int max, input string name);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (hit(which)) return;
    end
    n_cmp++;
    n_err++;
    $display("FAIL %s: timeout after %0d cycles", name, max);
  endtask

  // Controller model plus output monitor, evaluated away from the active edge.
  always @(negedge clk) begin
    cmd_t c;
    ack_t k;
    cyc++;
    ctl_data_ready = 1'b0;
    if (dr_cnt > 0) begin
      dr_cnt--;
      if (dr_cnt == 0) begin
        ctl_data_ready = 1'b1;
        ctl_data_out   = dr_data;
        if (in_txn)
          check("hold_fields", {37'd0, ctl_addr, ctl_write_en, ctl_burst_en},
                {37'd0, h_addr, h_we, h_burst});
      end
    end
    if (ctl_refresh_data) begin
      check("strobe_one_cycle", {63'd0, prev_str}, 64'd0);
      if (cmd_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_strobe: got addr %0h want no strobe", ctl_addr);
      end else begin
        c = cmd_q.pop_front();
        check("cmd_addr", {39'd0, ctl_addr}, {39'd0, c.addr});
        check("cmd_we_burst", {62'd0, ctl_write_en, ctl_burst_en}, {62'd0, c.we, c.burst});
        if (c.chk_din) check("cmd_din", {48'd0, ctl_data_in}, {48'd0, c.din});
      end
      h_addr  = ctl_addr;
      h_we    = ctl_write_en;
      h_burst = ctl_burst_en;
      in_txn  = 1'b1;
      str_cyc = cyc;
      if (!mute) begin
        dr_cnt = LAT;
        if (ctl_write_en) mem[ctl_addr] = ctl_data_in;
        dr_data = mem.exists(ctl_addr) ? mem[ctl_addr] : 16'h0;
      end
    end
    prev_str = ctl_refresh_data;
    if (rst) in_txn = 1'b0;
    if (cpu_ack || vid_ack) begin
      check("ack_one_cycle", {63'd0, prev_ack}, 64'd0);
      in_txn = 1'b0;
      if (ack_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_ack: got cpu %0b vid %0b want none", cpu_ack, vid_ack);
      end else begin
        k = ack_q.pop_front();
        check("ack_port", {62'd0, vid_ack, cpu_ack}, (k.port == 1'b1) ? 64'd2 : 64'd1);
        if (k.is_rd) check("cpu_rdata", {48'd0, cpu_rdata}, {48'd0, k.rdata});
        if (k.lat > 0) check("ack_latency", 64'(cyc - str_cyc), 64'(k.lat));
      end
    end
    prev_ack = cpu_ack | vid_ack;
  end

  task automatic cpu_agent(input int n);
    for (int i = 0; i < n; i++) begin
      cpu_addr  = 25'h200 + 25'(i);
      cpu_we    = 1'b1;
      cpu_wdata = (i == 0) ? 16'h1111 : 16'h2222;
      cpu_req   = 1'b1;
      wait_evt(0, 200, "rr_cpu_ack");
      cpu_req = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic vid_agent(input int n);
    for (int i = 0; i < n; i++) begin
      vid_addr = (i == 0) ? 25'h400 : 25'h827;
      vid_req  = 1'b1;
      wait_evt(1, 200, "rr_vid_ack");
      vid_req = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vid_req = 1'b0; vid_addr = '0; ctl_data_out = '0; ctl_data_ready = 1'b0;
    ctl_mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctl", {22'd0, ctl_refresh_data, ctl_write_en, ctl_burst_en, ctl_addr, ctl_data_in}, 64'd0);
    check("rst_status", {44'd0, busy, err, cpu_ack, vid_ack, cpu_rdata}, 64'd0);

    // Drain: mem_ready low for 10 cycles, then 64 ready cycles before IDLE.
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("drain_busy_early", {63'd0, busy}, 64'd1);
    ctl_mem_ready = 1'b1;
    repeat (TO - 1) @(posedge clk);
    #1 check("drain_busy_63", {63'd0, busy}, 64'd1);
    @(posedge clk);
    #1 check("drain_done_64", {63'd0, busy}, 64'd0);
    @(negedge clk);

    // CPU write then read-back of the same word.
    cpu_addr = 25'h0000123; cpu_we = 1'b1; cpu_wdata = 16'hBEEF;
    push_cmd(25'h123, 1'b1, 1'b0, 16'hBEEF, 1'b1);
    push_ack(1'b0, 1'b0, 16'h0, LAT + 1);
    cpu_req = 1'b1;
    wait_evt(0, 100, "wr_ack");
    cpu_req = 1'b0;
    @(negedge clk);
    cpu_we = 1'b0;
    push_cmd(25'h123, 1'b0, 1'b0, 16'hBEEF, 1'b1);
    push_ack(1'b0, 1'b1, 16'hBEEF, LAT + 1);
    cpu_req = 1'b1;
    wait_evt(0, 100, "rd_ack");
    cpu_req = 1'b0;
    @(negedge clk);

    // Video burst with unaligned base.
    vid_addr = 25'h0001F5A;
    push_cmd(25'h0001F40, 1'b0, 1'b1, 16'h0, 1'b0);
    push_ack(1'b1, 1'b0, 16'h0, LAT + 1);
    vid_req = 1'b1;
    wait_evt(1, 100, "vid_ack");
    vid_req = 1'b0;
    @(negedge clk);

    // Both ports contending: CPU wins first tie, then strict alternation.
    push_cmd(25'h200, 1'b1, 1'b0, 16'h1111, 1'b1); push_ack(1'b0, 1'b0, 16'h0, LAT + 1);
    push_cmd(25'h400, 1'b0, 1'b1, 16'h0, 1'b0);    push_ack(1'b1, 1'b0, 16'h0, LAT + 1);
    push_cmd(25'h201, 1'b1, 1'b0, 16'h2222, 1'b1); push_ack(1'b0, 1'b0, 16'h0, LAT + 1);
    push_cmd(25'h820, 1'b0, 1'b1, 16'h0, 1'b0);    push_ack(1'b1, 1'b0, 16'h0, LAT + 1);
    fork
      cpu_agent(2);
      vid_agent(2);
    join
    check("err_clear_before_to", {63'd0, err}, 64'd0);

    // Watchdog: controller never answers; rdata keeps the last read value.
    mute = 1'b1;
    cpu_addr = 25'h055; cpu_we = 1'b0; cpu_wdata = 16'h0;
    push_cmd(25'h055, 1'b0, 1'b0, 16'h0, 1'b1);
    push_ack(1'b0, 1'b1, 16'hBEEF, TO + 1);
    cpu_req = 1'b1;
    wait_evt(0, 200, "timeout_ack");
    cpu_req = 1'b0;
    check("err_set", {63'd0, err}, 64'd1);
    repeat (20) @(negedge clk);
    check("err_sticky", {63'd0, err}, 64'd1);
    mute = 1'b0;

    // Reset mid-burst; the in-flight data_ready lands in DRAIN and must be ignored.
    vid_addr = 25'h1000;
    push_cmd(25'h1000, 1'b0, 1'b1, 16'h0, 1'b0);
    vid_req = 1'b1;
    wait_evt(2, 50, "mid_strobe");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    vid_req = 1'b0;
    repeat (2) @(negedge clk);
    check("rst2_ctl", {22'd0, ctl_refresh_data, ctl_write_en, ctl_burst_en, ctl_addr, ctl_data_in}, 64'd0);
    check("rst2_err", {62'd0, err, busy}, 64'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("drain_after_rst_busy", {63'd0, busy}, 64'd1);
    check("drain_after_rst_err", {63'd0, err}, 64'd0);
    wait_evt(3, 100, "drain2_done");

    check("cmd_q_empty", 64'(cmd_q.size()), 64'd0);
    check("ack_q_empty", 64'(ack_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
